// File: rtl/divisor.sv
// Restoring unsigned divider, Q = A / B and R = A % B, one quotient bit per cycle; optional dz flag under DIVISOR_DZ_EN.
// Latency: done rises N+1 clock edges after the edge that samples start; operands are latched on that edge.
// Backpressure: start is ignored while busy; done and the result are held for as long as start stays high.
module divisor #(
    parameter int N = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    output logic         done,
    input  logic [N-1:0] A_in,
    input  logic [N-1:0] B_in,
    output logic [N-1:0] Q_out,
    output logic [N-1:0] R_out
`ifdef DIVISOR_DZ_EN
    ,
    output logic         dz
`endif
);

    localparam int CW = $clog2(N + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic [N-1:0]    a_q, a_d;
    logic [N-1:0]    b_q, b_d;
    logic [N-1:0]    r_q, r_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [N-1:0]    q_out_q, q_out_d;
    logic [N-1:0]    r_out_q, r_out_d;
    logic            done_q, done_d;
`ifdef DIVISOR_DZ_EN
    logic            dz_q, dz_d;
`endif

    logic [N:0]      shifted;
    logic [N-1:0]    diff;
    logic            fits;

    // The trial difference is only kept when shifted >= B, in which case it
    // is below B and fits in N bits, so the low N bits are sufficient.
    always_comb begin
        shifted = {r_q, a_q[N-1]};
        fits    = (shifted >= {1'b0, b_q});
        diff    = shifted[N-1:0] - b_q;
    end

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        r_d     = r_q;
        cnt_d   = cnt_q;
        q_out_d = q_out_q;
        r_out_d = r_out_q;
        done_d  = done_q;
`ifdef DIVISOR_DZ_EN
        dz_d    = dz_q;
`endif

        case (state_q)
            IDLE: begin
                done_d = 1'b0;
                if (start) begin
                    a_d     = A_in;
                    b_d     = B_in;
                    r_d     = '0;
                    cnt_d   = CW'(N);
                    state_d = CALC;
                end
            end

            CALC: begin
                if (cnt_q != '0) begin
                    a_d   = {a_q[N-2:0], fits};
                    r_d   = fits ? diff : shifted[N-1:0];
                    cnt_d = cnt_q - CW'(1);
                end else begin
                    // a_q now holds the quotient; B = 0 naturally yields all ones and R = A.
                    q_out_d = a_q;
                    r_out_d = r_q;
                    done_d  = 1'b1;
`ifdef DIVISOR_DZ_EN
                    dz_d    = (b_q == '0);
`endif
                    state_d = DONE;
                end
            end

            DONE: begin
                if (!start) begin
                    done_d  = 1'b0;
`ifdef DIVISOR_DZ_EN
                    dz_d    = 1'b0;
`endif
                    state_d = IDLE;
                end
            end

            default: begin
                done_d  = 1'b0;
`ifdef DIVISOR_DZ_EN
                dz_d    = 1'b0;
`endif
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            r_q     <= '0;
            cnt_q   <= '0;
            q_out_q <= '0;
            r_out_q <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            r_q     <= r_d;
            cnt_q   <= cnt_d;
            q_out_q <= q_out_d;
            r_out_q <= r_out_d;
            done_q  <= done_d;
        end
    end

`ifdef DIVISOR_DZ_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            dz_q <= 1'b0;
        end else begin
            dz_q <= dz_d;
        end
    end

    assign dz = dz_q;
`endif

    assign done  = done_q;
    assign Q_out = q_out_q;
    assign R_out = r_out_q;

endmodule

// File: tb/tb_divisor.sv
// Directed and randomized-operand bench for the divisor; builds with or without DIVISOR_DZ_EN.
module tb_divisor;

    localparam int N = 8;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic         done;
    logic [N-1:0] A_in;
    logic [N-1:0] B_in;
    logic [N-1:0] Q_out;
    logic [N-1:0] R_out;
`ifdef DIVISOR_DZ_EN
    logic         dz;
`endif

    int vectors     = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    divisor #(.N(N)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .done  (done),
        .A_in  (A_in),
        .B_in  (B_in),
        .Q_out (Q_out),
        .R_out (R_out)
`ifdef DIVISOR_DZ_EN
        ,
        .dz    (dz)
`endif
    );

    // Sample #1 after each edge until done; edges = 0 means the budget expired.
    task automatic wait_done(input bit scramble, output int edges);
        edges = 0;
        for (int i = 1; i <= 4 * N; i++) begin
            @(posedge clk);
            #1;
            if (done) begin
                edges = i;
                break;
            end
            if (scramble) begin
                A_in  = N'($urandom_range(0, 255));
                B_in  = N'($urandom_range(0, 255));
                start = (i < N - 2) ? 1'($urandom_range(0, 1)) : 1'b0;
            end
        end
    endtask

    task automatic launch(input logic [N-1:0] a, input logic [N-1:0] b, input bit hold);
        @(negedge clk);
        A_in  = a;
        B_in  = b;
        start = 1'b1;
        @(posedge clk);
        #1;
        if (!hold) start = 1'b0;
    endtask

    task automatic go_idle();
        @(negedge clk);
        start = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst   = 1'b0;
        start = 1'b0;
        A_in  = '0;
        B_in  = '0;
        #3;
        vectors++;
        if (done !== 1'b0) begin miscompares++; $display("FAIL reset_done: got %b expected 0", done); end
        vectors++;
        if (Q_out !== 8'd0) begin miscompares++; $display("FAIL reset_q: got %0d expected 0", Q_out); end
        vectors++;
        if (R_out !== 8'd0) begin miscompares++; $display("FAIL reset_r: got %0d expected 0", R_out); end
`ifdef DIVISOR_DZ_EN
        vectors++;
        if (dz !== 1'b0) begin miscompares++; $display("FAIL reset_dz: got %b expected 0", dz); end
`endif
    endtask

    task automatic test_first_start();
        int edges;
        // Release reset and request a division for the very first edge.
        @(negedge clk);
        rst   = 1'b1;
        A_in  = 8'd187;
        B_in  = 8'd11;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        A_in  = 8'd3;
        B_in  = 8'd200;
        wait_done(1'b0, edges);
        vectors++;
        if (edges !== N + 1) begin miscompares++; $display("FAIL first_latency: got %0d edges expected %0d", edges, N + 1); end
        vectors++;
        if (Q_out !== 8'd17) begin miscompares++; $display("FAIL first_q: got %0d expected 17", Q_out); end
        vectors++;
        if (R_out !== 8'd0) begin miscompares++; $display("FAIL first_r: got %0d expected 0", R_out); end
        go_idle();
    endtask

    task automatic test_start_held();
        int edges;
        launch(8'd200, 8'd7, 1'b1);
        wait_done(1'b0, edges);
        vectors++;
        if (edges !== N + 1) begin miscompares++; $display("FAIL held_latency: got %0d edges expected %0d", edges, N + 1); end
        vectors++;
        if (Q_out !== 8'd28) begin miscompares++; $display("FAIL held_q: got %0d expected 28", Q_out); end
        vectors++;
        if (R_out !== 8'd4) begin miscompares++; $display("FAIL held_r: got %0d expected 4", R_out); end
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            vectors++;
            if (done !== 1'b1) begin miscompares++; $display("FAIL held_done_%0d: got %b expected 1", i, done); end
        end
        go_idle();
        for (int i = 0; i < 3; i++) begin
            vectors++;
            if (done !== 1'b0) begin miscompares++; $display("FAIL idle_done_%0d: got %b expected 0", i, done); end
            vectors++;
            if (Q_out !== 8'd28 || R_out !== 8'd4)
                begin miscompares++; $display("FAIL idle_keep_%0d: got Q=%0d R=%0d expected Q=28 R=4", i, Q_out, R_out); end
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_boundaries();
        logic [N-1:0] tab_a [4] = '{8'd5, 8'd255, 8'd0, 8'd254};
        logic [N-1:0] tab_b [4] = '{8'd9, 8'd1, 8'd7, 8'd255};
        logic [N-1:0] tab_q [4] = '{8'd0, 8'd255, 8'd0, 8'd0};
        logic [N-1:0] tab_r [4] = '{8'd5, 8'd0, 8'd0, 8'd254};
        int edges;
        for (int i = 0; i < 4; i++) begin
            launch(tab_a[i], tab_b[i], 1'b0);
            wait_done(1'b0, edges);
            vectors++;
            if (edges !== N + 1) begin miscompares++; $display("FAIL bound_latency_%0d: got %0d expected %0d", i, edges, N + 1); end
            vectors++;
            if (Q_out !== tab_q[i]) begin miscompares++; $display("FAIL bound_q_%0d: got %0d expected %0d", i, Q_out, tab_q[i]); end
            vectors++;
            if (R_out !== tab_r[i]) begin miscompares++; $display("FAIL bound_r_%0d: got %0d expected %0d", i, R_out, tab_r[i]); end
`ifdef DIVISOR_DZ_EN
            vectors++;
            if (dz !== 1'b0) begin miscompares++; $display("FAIL bound_dz_%0d: got %b expected 0", i, dz); end
`endif
            go_idle();
        end
    endtask

    task automatic test_div_zero();
        int edges;
        launch(8'd100, 8'd0, 1'b0);
        wait_done(1'b0, edges);
        vectors++;
        if (edges !== N + 1) begin miscompares++; $display("FAIL dz_latency: got %0d expected %0d", edges, N + 1); end
        vectors++;
        if (Q_out !== 8'd255) begin miscompares++; $display("FAIL dz_q: got %0d expected 255", Q_out); end
        vectors++;
        if (R_out !== 8'd100) begin miscompares++; $display("FAIL dz_r: got %0d expected 100", R_out); end
`ifdef DIVISOR_DZ_EN
        vectors++;
        if (dz !== 1'b1) begin miscompares++; $display("FAIL dz_flag: got %b expected 1", dz); end
`endif
        go_idle();
        vectors++;
        if (done !== 1'b0) begin miscompares++; $display("FAIL dz_leave_done: got %b expected 0", done); end
`ifdef DIVISOR_DZ_EN
        vectors++;
        if (dz !== 1'b0) begin miscompares++; $display("FAIL dz_clear: got %b expected 0", dz); end
`endif
    endtask

    task automatic test_reset_mid_calc();
        int  edges;
        bit  saw_done;
        launch(8'd77, 8'd3, 1'b0);
        repeat (3) @(posedge clk);
        #2;
        rst = 1'b0;
        #1;
        vectors++;
        if (done !== 1'b0) begin miscompares++; $display("FAIL abort_done: got %b expected 0", done); end
        vectors++;
        if (Q_out !== 8'd0) begin miscompares++; $display("FAIL abort_q: got %0d expected 0", Q_out); end
        vectors++;
        if (R_out !== 8'd0) begin miscompares++; $display("FAIL abort_r: got %0d expected 0", R_out); end
        @(negedge clk);
        rst = 1'b1;
        saw_done = 1'b0;
        for (int i = 0; i < 2 * N + 4; i++) begin
            @(posedge clk);
            #1;
            if (done) saw_done = 1'b1;
        end
        vectors++;
        if (saw_done !== 1'b0) begin miscompares++; $display("FAIL abort_no_done: got %b expected 0", saw_done); end
        launch(8'd144, 8'd12, 1'b0);
        wait_done(1'b0, edges);
        vectors++;
        if (edges !== N + 1) begin miscompares++; $display("FAIL restart_latency: got %0d expected %0d", edges, N + 1); end
        vectors++;
        if (Q_out !== 8'd12) begin miscompares++; $display("FAIL restart_q: got %0d expected 12", Q_out); end
        vectors++;
        if (R_out !== 8'd0) begin miscompares++; $display("FAIL restart_r: got %0d expected 0", R_out); end
        go_idle();
    endtask

    task automatic test_random_operands();
        logic [N-1:0] a, b, eq, er;
        int edges;
        for (int i = 0; i < 24; i++) begin
            a  = N'($urandom_range(0, 255));
            b  = (i % 7 == 3) ? 8'd0 : N'($urandom_range(1, 255));
            eq = (b == 8'd0) ? 8'hFF : a / b;
            er = (b == 8'd0) ? a : a % b;
            launch(a, b, 1'b0);
            wait_done(1'b1, edges);
            vectors++;
            if (edges !== N + 1) begin miscompares++; $display("FAIL rand_latency_%0d: got %0d expected %0d", i, edges, N + 1); end
            vectors++;
            if (Q_out !== eq) begin miscompares++; $display("FAIL rand_q_%0d: A=%0d B=%0d got %0d expected %0d", i, a, b, Q_out, eq); end
            vectors++;
            if (R_out !== er) begin miscompares++; $display("FAIL rand_r_%0d: A=%0d B=%0d got %0d expected %0d", i, a, b, R_out, er); end
`ifdef DIVISOR_DZ_EN
            vectors++;
            if (dz !== (b == 8'd0)) begin miscompares++; $display("FAIL rand_dz_%0d: got %b expected %b", i, dz, (b == 8'd0)); end
`endif
            go_idle();
        end
    endtask

    initial begin
        test_reset();
        test_first_start();
        test_start_held();
        test_boundaries();
        test_div_zero();
        test_reset_mid_calc();
        test_random_operands();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running at %0t, expected completion", $time);
        $fatal(1);
    end

endmodule

// File: doc/divisor.md
DIVISOR -- requirements
Module: divisor

Interface
REQ-001 The block SHALL have parameter N, default 8, meaning the operand width in bits.
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-003 The block SHALL have port rst, input, 1 bit: reset, asynchronous and active-low.
REQ-004 The block SHALL have port start, input, 1 bit: request to begin a division.
REQ-005 The block SHALL have port done, output, 1 bit: high when Q_out/R_out hold the valid result of the last operation.
REQ-006 The block SHALL have port A_in, input, N bits: the unsigned dividend.
REQ-007 The block SHALL have port B_in, input, N bits: the unsigned divisor.
REQ-008 The block SHALL have port Q_out, output, N bits: the quotient.
REQ-009 The block SHALL have port R_out, output, N bits: the remainder.
REQ-010 The block SHALL have port dz, output, 1 bit: divide-by-zero flag, present only when DIVISOR_DZ_EN is defined.

Function
REQ-011 The block SHALL implement an FSM with the states IDLE, CALC and DONE; state, done and all outputs are registered.
REQ-012 In IDLE with start=1 at a rising edge, the block SHALL latch A_in and B_in, clear the partial remainder, load the iteration counter with N and enter CALC.
REQ-013 Changes on A_in/B_in after the sampling edge SHALL NOT affect the result.
REQ-014 In CALC, each cycle SHALL perform one restoring step: shift {remainder, dividend} left by one, trial-subtract the divisor on N+1 bits, keep the difference if it is non-negative and shift in quotient bit 1, else restore and shift in 0.
REQ-015 After exactly N CALC cycles the block SHALL enter DONE; done goes high after edge k+N+1, where k is the start-sampling edge.
REQ-016 In DONE, done SHALL be 1 and Q_out = floor(A/B), R_out = A mod B, with R_out < B whenever B != 0.
REQ-017 DONE SHALL return to IDLE at the first rising edge with start=0; done is high for at least one cycle and stays high while start stays 1, so no automatic restart occurs.
REQ-018 In IDLE, Q_out/R_out SHALL keep the last result and done SHALL be 0.
REQ-019 start during CALC SHALL be ignored.
REQ-020 For B=0, the block SHALL run the normal N cycles and produce Q_out = all ones and R_out = A, with no hang and no special latency.

Reset
REQ-021 When rst=0, the block SHALL immediately, regardless of clock, go to IDLE with done=0, Q_out=0, R_out=0, internal registers and counter at 0, and dz=0 when present.
REQ-022 A reset mid-CALC SHALL abort the operation; after rst returns high, no done is asserted until a new start.
REQ-023 The first start sampled in the first edge after reset release SHALL be honoured.

Configuration
REQ-024 When macro DIVISOR_DZ_EN is defined, the block SHALL provide port dz, set to 1 in DONE if the latched B was 0 (else 0) and cleared on leaving DONE, with Q_out/R_out per REQ-020.
REQ-025 When DIVISOR_DZ_EN is undefined, the dz port and its logic SHALL be absent, with all other behaviour identical.

Verification
REQ-026 The bench SHALL cover: N=8, A=187, B=11, start pulse -> done exactly N+1 edges after the sampling edge, Q=17, R=0.
REQ-027 The bench SHALL cover: A=200, B=7, start held high -> Q=28, R=4, done stays 1 until start drops, then IDLE with Q/R retained.
REQ-028 The bench SHALL cover: A=5, B=9 -> Q=0, R=5; and A=255, B=1 -> Q=255, R=0.
REQ-029 The bench SHALL cover: A=100, B=0 -> Q=255, R=100, and dz=1 with DIVISOR_DZ_EN defined (port absent without it).
REQ-030 The bench SHALL cover: rst pulled low 3 cycles into CALC -> outputs 0 at once, no done afterwards; then a new start with A=144, B=12 -> Q=12, R=0.
REQ-031 The bench SHALL cover: A_in/B_in changed randomly during CALC -> result still matches the operands latched at start; a randomized loop compared against A/B and A%B.
